// File: rtl/alsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_pkg
//  Description : Shared types and seven-segment constants for the ALSU
//                result display.
//  Revision    : 1.0 - initial release
// ============================================================================
package alsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_R     = 7'b0000101;

    // Segment pattern {a,b,c,d,e,f,g} for each hex value, index = nibble.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b1000111,  // F
        7'b1001111,  // E
        7'b0111101,  // d
        7'b1001110,  // C
        7'b0011111,  // b
        7'b1110111,  // A
        7'b1111011,  // 9
        7'b1111111,  // 8
        7'b1110000,  // 7
        7'b1011111,  // 6
        7'b1011011,  // 5
        7'b0110011,  // 4
        7'b1111001,  // 3
        7'b1101101,  // 2
        7'b0110000,  // 1
        7'b1111110   // 0
    };

endpackage : alsu_pkg
`default_nettype wire

// File: rtl/alsu_seg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_seg_decode
//  Description : Combinational 4-bit to seven-segment (active-high) decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module alsu_seg_decode
    import alsu_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_HEX[nibble];
    end

endmodule : alsu_seg_decode
`default_nettype wire

// File: rtl/alsu_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : alsu_seg_display
//  Description : Multiplexed 4-digit display of the ALSU result with an
//                "Err" message and LED blink episode on rejected operations.
//                Define ALSU_SEG_DECIMAL_EN for decimal instead of hex digits.
//  Revision    : 1.0 - initial release
// ============================================================================
module alsu_seg_display
    import alsu_pkg::*;
#(
    parameter int REFRESH_DIV   = 4,
    parameter int BLINK_HALF    = 8,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  result,
    input  logic        result_valid,
    input  logic        invalid,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic [15:0] leds
);

    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] BLINK_LAST   = 16'(BLINK_HALF - 1);
    localparam logic [15:0] TOGGLE_LAST  = 16'(BLINK_TOGGLES - 1);

    state_t      state_q,     state_d;
    logic [5:0]  disp_val_q,  disp_val_d;
    logic [15:0] refresh_q,   refresh_d;
    logic [1:0]  digit_q,     digit_d;
    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic [15:0] toggle_q,    toggle_d;
    logic [3:0]  anode_q,     anode_d;
    logic [6:0]  cathode_q,   cathode_d;

    logic [3:0]  w_lo_nib;
    logic [3:0]  w_hi_nib;
    logic [3:0]  w_nibble;
    logic [6:0]  w_hex_seg;

    // Scan timing and state transitions
    always_comb begin
        state_d     = state_q;
        disp_val_d  = disp_val_q;
        refresh_d   = refresh_q + 16'd1;
        digit_d     = digit_q;
        blink_cnt_d = blink_cnt_q;
        toggle_d    = toggle_q;

        if (refresh_q == REFRESH_LAST) begin
            refresh_d = 16'd0;
            digit_d   = digit_q + 2'd1;
        end

        if (invalid) begin
            state_d     = ST_ERROR;
            blink_cnt_d = 16'd0;
            toggle_d    = 16'd0;
        end else begin
            if (result_valid) begin
                disp_val_d = result;
            end
            case (state_q)
                ST_IDLE: begin
                    if (result_valid) begin
                        state_d = ST_SHOW;
                    end
                end
                ST_ERROR: begin
                    if (blink_cnt_q == BLINK_LAST) begin
                        blink_cnt_d = 16'd0;
                        if (toggle_q == TOGGLE_LAST) begin
                            toggle_d = 16'd0;
                            state_d  = ST_SHOW;
                        end else begin
                            toggle_d = toggle_q + 16'd1;
                        end
                    end else begin
                        blink_cnt_d = blink_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

`ifdef ALSU_SEG_DECIMAL_EN
    always_comb begin
        w_lo_nib = 4'(disp_val_q % 6'd10);
        w_hi_nib = 4'(disp_val_q / 6'd10);
    end
`else
    always_comb begin
        w_lo_nib = disp_val_q[3:0];
        w_hi_nib = {2'b00, disp_val_q[5:4]};
    end
`endif

    assign w_nibble = digit_q[0] ? w_hi_nib : w_lo_nib;

    alsu_seg_decode u_decode (
        .nibble (w_nibble),
        .seg    (w_hex_seg)
    );

    // Outputs are computed from the current index and registered next edge.
    always_comb begin
        anode_d   = 4'b0000;
        cathode_d = SEG_BLANK;
        case (state_q)
            ST_SHOW: begin
                anode_d   = 4'b0001 << digit_q;
                cathode_d = digit_q[1] ? SEG_BLANK : w_hex_seg;
            end
            ST_ERROR: begin
                anode_d = 4'b0001 << digit_q;
                case (digit_q)
                    2'd0:    cathode_d = SEG_BLANK;
                    2'd3:    cathode_d = SEG_E;
                    default: cathode_d = SEG_R;
                endcase
            end
            default: begin
                anode_d   = 4'b0000;
                cathode_d = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            disp_val_q  <= 6'd0;
            refresh_q   <= 16'd0;
            digit_q     <= 2'd0;
            blink_cnt_q <= 16'd0;
            toggle_q    <= 16'd0;
            anode_q     <= 4'b0000;
            cathode_q   <= SEG_BLANK;
        end else begin
            state_q     <= state_d;
            disp_val_q  <= disp_val_d;
            refresh_q   <= refresh_d;
            digit_q     <= digit_d;
            blink_cnt_q <= blink_cnt_d;
            toggle_q    <= toggle_d;
            anode_q     <= anode_d;
            cathode_q   <= cathode_d;
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;
    // Even phases light the LEDs; the phase parity is the toggle count's LSB.
    assign leds    = (state_q == ST_ERROR && !toggle_q[0]) ? 16'hFFFF : 16'h0000;

endmodule : alsu_seg_display
`default_nettype wire

// File: tb/tb_alsu_seg_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alsu_seg_display
//  Description : Scoreboard bench for alsu_seg_display; expected outputs per
//                clock edge are queued with the stimulus and popped by a monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alsu_seg_display;

    localparam int NK     = 240;
    localparam int S_IDLE = 0;
    localparam int S_SHOW = 1;
    localparam int S_ERR  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  result;
    logic        result_valid;
    logic        invalid;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic [15:0] leds;

    always #5 clk = ~clk;

    alsu_seg_display #(
        .REFRESH_DIV   (4),
        .BLINK_HALF    (8),
        .BLINK_TOGGLES (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .result       (result),
        .result_valid (result_valid),
        .invalid      (invalid),
        .anode        (anode),
        .cathode      (cathode),
        .leds         (leds)
    );

    typedef struct {
        int          k;
        logic [3:0]  an;
        logic [6:0]  ca;
        logic [15:0] ld;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt = 0;

    // Planned behaviour after each clock edge: state, value, error start, last reset edge
    int st_e [NK+1];
    int val_e[NK+1];
    int es_e [NK+1];
    int rs_e [NK+1];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [6:0] hseg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    function automatic logic [6:0] show_seg(input int v, input int d);
`ifdef ALSU_SEG_DECIMAL_EN
        if (d == 0) return hseg(4'(v % 10));
        if (d == 1) return hseg(4'(v / 10));
`else
        if (d == 0) return hseg(4'(v % 16));
        if (d == 1) return hseg(4'(v / 16));
`endif
        return 7'b0000000;
    endfunction

    function automatic exp_t exp_of(input int k);
        exp_t e;
        int   m;
        int   d;
        e.k  = k;
        e.an = 4'b0000;
        e.ca = 7'b0000000;
        e.ld = 16'h0000;
        if (st_e[k] == S_ERR && (((k - es_e[k]) / 8) % 2) == 0) e.ld = 16'hFFFF;
        if (rs_e[k] != k) begin
            m = k - 1;
            d = ((m - rs_e[m]) / 4) % 4;
            if (st_e[m] == S_SHOW) begin
                e.an = 4'(1 << d);
                e.ca = show_seg(val_e[m], d);
            end else if (st_e[m] == S_ERR) begin
                e.an = 4'(1 << d);
                e.ca = (d == 0) ? 7'b0000000 : (d == 3) ? 7'b1001111 : 7'b0000101;
            end
        end
        return e;
    endfunction

    task automatic plan(input int k0, input int k1, input int st, input int v,
                        input int es, input int rs);
        for (int k = k0; k <= k1; k++) begin
            st_e[k]  = st;
            val_e[k] = v;
            es_e[k]  = es;
            rs_e[k]  = (rs < 0) ? k : rs;
        end
    endtask

    task automatic push(input int k0, input int k1);
        for (int k = k0; k <= k1; k++) sbq.push_back(exp_of(k));
    endtask

    // Drive so that the values are sampled by clock edge m
    task automatic at_edge(input int m);
        while (edge_cnt != m - 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].k < edge_cnt) begin
                e = sbq.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_edge k=%0d now=%0d", e.k, edge_cnt);
            end
            if (sbq.size() > 0 && sbq[0].k == edge_cnt) begin
                e = sbq.pop_front();
                checks++;
                if (anode !== e.an) begin
                    failures++;
                    $display("FAIL anode k=%0d got=%b want=%b", e.k, anode, e.an);
                end
                checks++;
                if (cathode !== e.ca) begin
                    failures++;
                    $display("FAIL cathode k=%0d got=%b want=%b", e.k, cathode, e.ca);
                end
                checks++;
                if (leds !== e.ld) begin
                    failures++;
                    $display("FAIL leds k=%0d got=%h want=%h", e.k, leds, e.ld);
                end
            end
        end
    end

    initial begin : stimulus
        int budget;
        rst          = 1'b1;
        result       = 6'h00;
        result_valid = 1'b0;
        invalid      = 1'b0;
        st_e[0] = S_IDLE; val_e[0] = 0; es_e[0] = 0; rs_e[0] = 0;

        plan(1, 3, S_IDLE, 0, 0, -1);
        plan(4, 4, S_IDLE, 0, 0, 3);
        push(1, 4);
        at_edge(4);
        rst = 1'b0;

        // First result 0x2B, then free-running scan in SHOW
        at_edge(5);
        result = 6'h2B; result_valid = 1'b1;
        plan(5, 29, S_SHOW, 'h2B, 0, 3);
        push(5, 29);
        at_edge(6);
        result_valid = 1'b0;

        // Full error episode then back to SHOW with 0x2B
        at_edge(30);
        invalid = 1'b1;
        plan(30, 77, S_ERR, 'h2B, 30, 3);
        plan(78, 84, S_SHOW, 'h2B, 0, 3);
        push(30, 84);
        at_edge(31);
        invalid = 1'b0;

        // invalid together with result_valid: value must not change
        at_edge(85);
        invalid = 1'b1; result_valid = 1'b1; result = 6'h11;
        plan(85, 99, S_ERR, 'h2B, 85, 3);
        push(85, 99);
        at_edge(86);
        invalid = 1'b0; result_valid = 1'b0;

        // Second invalid mid-blink restarts the episode
        at_edge(100);
        invalid = 1'b1;
        plan(100, 147, S_ERR, 'h2B, 100, 3);
        plan(148, 154, S_SHOW, 'h2B, 0, 3);
        push(100, 154);
        at_edge(101);
        invalid = 1'b0;

        at_edge(155);
        result = 6'd63; result_valid = 1'b1;
        plan(155, 169, S_SHOW, 63, 0, 3);
        push(155, 169);
        at_edge(156);
        result_valid = 1'b0;

        // Reset lands in blink phase 3, with competing invalid/result_valid
        at_edge(170);
        invalid = 1'b1;
        plan(170, 196, S_ERR, 63, 170, 3);
        push(170, 196);
        at_edge(171);
        invalid = 1'b0;

        at_edge(197);
        rst = 1'b1; invalid = 1'b1; result_valid = 1'b1; result = 6'h15;
        plan(197, 197, S_IDLE, 0, 0, -1);
        plan(198, 205, S_IDLE, 0, 0, 197);
        push(197, 205);
        at_edge(198);
        rst = 1'b0; invalid = 1'b0; result_valid = 1'b0;

        at_edge(206);
        result = 6'h0A; result_valid = 1'b1;
        plan(206, 225, S_SHOW, 'h0A, 0, 197);
        push(206, 225);
        at_edge(207);
        result_valid = 1'b0;

        budget = 0;
        while (sbq.size() > 0 && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        repeat (2) @(posedge clk);
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d want=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alsu_seg_display
`default_nettype wire

// File: doc/alsu_seg_display.md
ALSU_SEG_DISPLAY -- requirements
Module: alsu_seg_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 4: clocks each digit stays selected, legal range 2..65535.
REQ-002 SHALL have parameter BLINK_HALF, default 8: clocks per LED on/off phase during error, legal range 1..65535.
REQ-003 SHALL have parameter BLINK_TOGGLES, default 6: number of LED phases per error episode, must be even.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port result  input  6  ALSU registered result.
REQ-007 SHALL have port result_valid  input  1  one-cycle pulse, result is new.
REQ-008 SHALL have port invalid  input  1  one-cycle pulse, ALSU rejected an opcode/reduction combination.
REQ-009 SHALL have port anode  output  4  one-hot digit select, active-high, bit0 = rightmost digit.
REQ-010 SHALL have port cathode  output  7  segments {a,b,c,d,e,f,g} on bits 6..0, active-high.
REQ-011 SHALL have port leds  output  16  error blink indication.

Function
REQ-012 SHALL implement states IDLE, SHOW, ERROR.
- IDLE -> SHOW on result_valid.
- IDLE/SHOW/ERROR -> ERROR on invalid.
- ERROR -> SHOW when BLINK_TOGGLES phases have completed.
REQ-013 SHALL latch result into disp_val on result_valid when invalid is low, in any state.
REQ-014 SHALL, when invalid and result_valid coincide, take the invalid path and leave disp_val unchanged.
REQ-015 SHALL restart the blink phase and toggle counts from zero when invalid arrives while already in ERROR.
REQ-016 SHALL run refresh counter 0..REFRESH_DIV-1 in every state.
- At wrap, digit index advances 0->1->2->3->0.
REQ-017 SHALL register anode and cathode from the current digit index, state and disp_val.
- Outputs therefore lag a digit-index change by exactly one clock.
REQ-018 SHALL drive anode = 4'b0000 and cathode = 7'b0000000 in IDLE.
REQ-019 SHALL, in SHOW (hex mode), display:
- digit0 = hex of disp_val[3:0]
- digit1 = hex of {2'b00, disp_val[5:4]}
- digits 2 and 3 blank, anode still scanning.
REQ-020 SHALL, in ERROR, display digit3 'E', digit2 'r', digit1 'r', digit0 blank.
REQ-021 SHALL drive leds = 16'hFFFF on even phases and 16'h0000 on odd phases of ERROR.
- Each phase lasts BLINK_HALF clocks.
- Phase 0 begins the clock after invalid.
- leds = 0 outside ERROR.
REQ-022 SHALL resume SHOW with the latest disp_val on leaving ERROR.

Reset
REQ-023 SHALL, on rst high at a clock edge, set:
- state IDLE
- disp_val 0, refresh counter 0, digit index 0, blink counters 0
- anode 0, cathode 0, leds 0.
REQ-024 SHALL give rst priority over invalid and result_valid in the same cycle.
REQ-025 SHALL abandon any in-progress ERROR episode on reset, with leds 0 the cycle after.

Configuration
REQ-026 SHALL, with macro ALSU_SEG_DECIMAL_EN defined, display disp_val in decimal:
- digit0 = disp_val mod 10
- digit1 = disp_val / 10 (0..6)
- digits 2 and 3 blank.
REQ-027 SHALL, without ALSU_SEG_DECIMAL_EN, use the hex mapping of REQ-019; no decimal logic synthesised.

Structure
REQ-028 SHALL take from shared package alsu_pkg:
- the state enum
- segment constants: SEG_BLANK=7'b0000000, SEG_E=7'b1001111, SEG_R=7'b0000101
- hex codes 0..F (0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111).
REQ-029 SHALL implement 4-bit-to-segment conversion in a single combinational sub-module alsu_seg_decode.

Verification
REQ-030 SHALL cover: reset then result=6'h2B with result_valid -> SHOW, digit0 cathode 7'b0011111 ('b'), digit1 cathode 7'b1101101 ('2'), digits 2/3 7'b0000000.
REQ-031 SHALL cover: REFRESH_DIV=4 -> anode sequence 0001,0010,0100,1000 repeating, each held 4 clocks, one clock after index change.
REQ-032 SHALL cover: invalid pulse with BLINK_HALF=8, BLINK_TOGGLES=6 -> leds FFFF 8 clocks, 0000 8 clocks, x3, then SHOW with prior value; display E,r,r,blank throughout.
REQ-033 SHALL cover: invalid and result_valid(result=6'h11) same cycle -> ERROR, disp_val unchanged; second invalid mid-blink -> blink restarts at phase 0.
REQ-034 SHALL cover: rst asserted during ERROR phase 3 -> next cycle IDLE, leds 0, anode 0.
REQ-035 SHALL cover: with ALSU_SEG_DECIMAL_EN, result=6'd63 -> digit0 '3' (1111001), digit1 '6' (1011111).
